mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter_load_extend.sv | 29 ++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    W_BYTE  = 3'd0,
    W_HALF  = 3'd1,
    W_WORD  = 3'd2,
    W_DWORD = 3'd3
  } width_t;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int WAIT_CNT_W      = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and shared memory bus of the arbiter, bundled as one interface.
interface mem_arbiter_if;
  logic        if_req_in;
  logic [31:0] if_addr_in;
  logic        if_ready_out;
  logic [63:0] if_rdata_out;
  logic        if_err_out;

  logic        d_req_in;
  logic        d_write_in;
  logic [31:0] d_addr_in;
  logic [63:0] d_wdata_in;
  logic [2:0]  d_width_in;
  logic        d_zero_extend_in;
  logic        d_ready_out;
  logic [63:0] d_rdata_out;
  logic        d_err_out;

  logic        mem_valid_out;
  logic        mem_write_out;
  logic [31:0] mem_addr_out;
  logic [63:0] mem_wdata_out;
  logic [2:0]  mem_width_out;
  logic        mem_ready_in;
  logic [63:0] mem_rdata_in;

  // Arbiter side
  modport slave (
    input  if_req_in, if_addr_in,
    output if_ready_out, if_rdata_out, if_err_out,
    input  d_req_in, d_write_in, d_addr_in, d_wdata_in, d_width_in, d_zero_extend_in,
    output d_ready_out, d_rdata_out, d_err_out,
    output mem_valid_out, mem_write_out, mem_addr_out, mem_wdata_out, mem_width_out,
    input  mem_ready_in, mem_rdata_in
  );

  // Requestor + memory side
  modport master (
    output if_req_in, if_addr_in,
    input  if_ready_out, if_rdata_out, if_err_out,
    output d_req_in, d_write_in, d_addr_in, d_wdata_in, d_width_in, d_zero_extend_in,
    input  d_ready_out, d_rdata_out, d_err_out,
    input  mem_valid_out, mem_write_out, mem_addr_out, mem_wdata_out, mem_width_out,
    output mem_ready_in, mem_rdata_in
  );
endinterface

// File: rtl/mem_arbiter_load_extend.sv
// Combinational load-data extraction: low 8/16/32/64 bits, zero- or sign-extended to 64.
module load_extend
  import mem_arbiter_pkg::*;
(
  input  logic [2:0]  width,
  input  logic        zero_extend,
  input  logic [63:0] raw,
  output logic [63:0] ext
);

  function automatic logic [63:0] extend(input logic [63:0] d, input logic [2:0] w,
                                         input logic z);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] wd;
    b  = d[7:0];
    h  = d[15:0];
    wd = d[31:0];
    case (w)
      W_BYTE:  extend = z ? {56'd0, d[7:0]}  : 64'(b);
      W_HALF:  extend = z ? {48'd0, d[15:0]} : 64'(h);
      W_WORD:  extend = z ? {32'd0, d[31:0]} : 64'(wd);
      default: extend = d;
    endcase
  endfunction

  assign ext = extend(raw, width, zero_extend);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single registered memory bus, one access in flight,
// alternating priority under contention and a per-access wait timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  mem_arbiter_if.slave   bus
);

  localparam logic [WAIT_CNT_W-1:0] TO_LAST = WAIT_CNT_W'(TIMEOUT - 1);

  state_t                state, state_nxt;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  last_data;
  logic                  zext_q;
  logic                  pulse_busy;
  logic                  grant_data, grant_fetch;
  logic                  mem_done, mem_tout;
  logic [63:0]           load_data;

  load_extend u_load_extend (
    .width       (bus.mem_width_out),
    .zero_extend (zext_q),
    .raw         (bus.mem_rdata_in),
    .ext         (load_data)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (grant_data)       state_nxt = ST_DATA;
        else if (grant_fetch) state_nxt = ST_FETCH;
      end
      ST_FETCH, ST_DATA: begin
        if (mem_done || mem_tout) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The completion-pulse cycle is spent in IDLE without granting, so a requestor that
  // drops its request on seeing ready is never granted a second time.
  always_comb begin
    pulse_busy  = bus.if_ready_out | bus.d_ready_out;
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    mem_done    = 1'b0;
    mem_tout    = 1'b0;
    if (state == ST_IDLE) begin
      if (!pulse_busy) begin
        grant_data  = bus.d_req_in && (!bus.if_req_in || !last_data);
        grant_fetch = bus.if_req_in && !grant_data;
      end
    end else begin
      mem_done = bus.mem_ready_in;
      mem_tout = !bus.mem_ready_in && (wait_cnt == TO_LAST);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bus.mem_valid_out <= 1'b0;
      bus.mem_write_out <= 1'b0;
      bus.mem_addr_out  <= '0;
      bus.mem_wdata_out <= '0;
      bus.mem_width_out <= '0;
      bus.if_ready_out  <= 1'b0;
      bus.if_err_out    <= 1'b0;
      bus.if_rdata_out  <= '0;
      bus.d_ready_out   <= 1'b0;
      bus.d_err_out     <= 1'b0;
      bus.d_rdata_out   <= '0;
      wait_cnt          <= '0;
      last_data         <= 1'b0;
      zext_q            <= 1'b0;
    end else begin
      bus.if_ready_out <= 1'b0;
      bus.if_err_out   <= 1'b0;
      bus.d_ready_out  <= 1'b0;
      bus.d_err_out    <= 1'b0;
      if (grant_data) begin
        bus.mem_valid_out <= 1'b1;
        bus.mem_write_out <= bus.d_write_in;
        bus.mem_addr_out  <= bus.d_addr_in;
        bus.mem_wdata_out <= bus.d_wdata_in;
        bus.mem_width_out <= bus.d_width_in;
        zext_q            <= bus.d_zero_extend_in;
        wait_cnt          <= '0;
      end else if (grant_fetch) begin
        bus.mem_valid_out <= 1'b1;
        bus.mem_write_out <= 1'b0;
        bus.mem_addr_out  <= bus.if_addr_in;
        bus.mem_wdata_out <= '0;
        bus.mem_width_out <= W_DWORD;
        wait_cnt          <= '0;
      end else if (mem_done || mem_tout) begin
        bus.mem_valid_out <= 1'b0;
        last_data         <= (state == ST_DATA);
        if (state == ST_FETCH) begin
          bus.if_ready_out <= 1'b1;
          bus.if_err_out   <= mem_tout;
          bus.if_rdata_out <= mem_done ? bus.mem_rdata_in : 64'd0;
        end else begin
          bus.d_ready_out <= 1'b1;
          bus.d_err_out   <= mem_tout;
          bus.d_rdata_out <= (mem_done && !bus.mem_write_out) ? load_data : 64'd0;
        end
      end else if (state != ST_IDLE) begin
        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
      end
    end
  end

endmodule
